// File: rtl/multibyte_rx.sv
// -----------------------------------------------------------------------------
// multibyte_rx
//   UART receiver (8N1, LSB first) that collects NUM_BYTES consecutive frames
//   and assembles them into one word. The first byte received lands in
//   data[7:0], the next in data[15:8], and so on. The assembled word appears
//   on data only when every slot has been received. valid pulses for one
//   clock each time data updates.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit time (must be >= 4)
//   NUM_BYTES     bytes per word; word width = 8*NUM_BYTES
//   TIMEOUT_BITS  inter-byte timeout in bit times
//
// Ports
//   clock      in   system clock
//   reset      in   asynchronous active-low reset (0 = reset)
//   RxD        in   serial line, idle high
//   data       out  last complete word, held until the next word completes
//   valid      out  1-cycle pulse when data updates
//   frame_err  out  1-cycle pulse on a low stop bit (or on an inter-byte timeout)
//   busy       out  high whenever the receiver is not idle
//
// Build option
//   MULTIBYTE_RX_TIMEOUT_EN : when defined, a partial word that sees no new
//   start bit for more than TIMEOUT_BITS*CLKS_PER_BIT clocks is dropped and
//   frame_err pulses once. When undefined, a partial word waits indefinitely.
// -----------------------------------------------------------------------------
module multibyte_rx #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int NUM_BYTES    = 2,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   RxD,
   output logic [8*NUM_BYTES-1:0] data,
   output logic                   valid,
   output logic                   frame_err,
   output logic                   busy
);

   localparam int WW = 8 * NUM_BYTES;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   localparam logic [CW-1:0] CNT_MID      = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] CNT_LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_BYTES - 1);

`ifdef MULTIBYTE_RX_TIMEOUT_EN
   localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW      = $clog2(TO_CLKS + 2);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TO_CLKS);
`endif

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t          state_q;
   logic            rx_meta_q;
   logic            rxs_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic [IW-1:0]   idx_q;
   logic [WW-1:0]   word_q;
   logic [WW-1:0]   word_d;
   logic [WW-1:0]   data_q;
   logic            valid_q;
   logic            frame_err_q;
`ifdef MULTIBYTE_RX_TIMEOUT_EN
   logic [TW-1:0]   idle_cnt_q;
`endif

   // Word with the just-received byte dropped into the current slot; used both
   // to update the partial word and, on the last slot, to publish data.
   always_comb begin
      // NOTE: give every combinational output a default first so no path can
      // leave it unassigned and infer a latch.
      word_d = word_q;
      word_d[int'(idx_q) * 8 +: 8] = shift_q;
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rx_meta_q   <= 1'b1;
         rxs_q       <= 1'b1;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         idx_q       <= '0;
         word_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef MULTIBYTE_RX_TIMEOUT_EN
         idle_cnt_q  <= '0;
`endif
      end else begin
         // Two-flop synchronizer; only rxs_q is used below.
         rx_meta_q   <= RxD;
         rxs_q       <= rx_meta_q;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (!rxs_q) begin
                  state_q <= START;
                  cnt_q   <= '0;
`ifdef MULTIBYTE_RX_TIMEOUT_EN
                  idle_cnt_q <= '0;
`endif
               end
`ifdef MULTIBYTE_RX_TIMEOUT_EN
               else if (idx_q != '0) begin
                  // Partial word outstanding: drop it if the gap runs too long.
                  if (idle_cnt_q > TO_LIMIT) begin
                     idx_q       <= '0;
                     frame_err_q <= 1'b1;
                     idle_cnt_q  <= '0;
                  end else begin
                     idle_cnt_q <= idle_cnt_q + 1'b1;
                  end
               end
`endif
            end

            START: begin
               // Re-check the line mid start bit to reject short glitches.
               if (cnt_q == CNT_MID) begin
                  cnt_q <= '0;
                  if (!rxs_q) begin
                     state_q <= DATA;
                     bit_q   <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            DATA: begin
               // Counter restarted at mid start bit, so the wrap lands mid bit.
               if (cnt_q == CNT_LAST) begin
                  cnt_q          <= '0;
                  shift_q[bit_q] <= rxs_q;
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (rxs_q) begin
                     word_q  <= word_d;
                     state_q <= IDLE;
                     if (idx_q == IDX_LAST) begin
                        data_q  <= word_d;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     idx_q       <= '0;
                     state_q     <= BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            BREAK: begin
               // Hold here while the line stays low so one break gives one error.
               if (rxs_q) begin
                  state_q <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_multibyte_rx.sv
// -----------------------------------------------------------------------------
// tb_multibyte_rx
//   Directed bench for multibyte_rx with CLKS_PER_BIT=16, NUM_BYTES=2.
//   Frames are driven on the falling clock edge; outputs are sampled on the
//   falling edge as well. valid / frame_err pulses are counted by a monitor.
// -----------------------------------------------------------------------------
module tb_multibyte_rx;

   localparam int CPB = 16;
   localparam int NB  = 2;
   localparam int TOB = 20;

   logic          clock;
   logic          reset;
   logic          RxD;
   logic [15:0]   data;
   logic          valid;
   logic          frame_err;
   logic          busy;

   int n_checks = 0;
   int n_pass   = 0;

   int valid_cnt = 0;
   int fe_cnt    = 0;
   int both_cnt  = 0;
   int exp_valid = 0;
   int exp_fe    = 0;

   multibyte_rx #(
      .CLKS_PER_BIT (CPB),
      .NUM_BYTES    (NB),
      .TIMEOUT_BITS (TOB)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .RxD       (RxD),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (valid)              valid_cnt++;
      if (frame_err)          fe_cnt++;
      if (valid && frame_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic idle_clks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      RxD = 1'b0;
      idle_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         idle_clks(CPB);
      end
      RxD = stop_bit;
      idle_clks(CPB);
      RxD = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      RxD   = 1'b1;
      idle_clks(3);
      check("rst_data",  {16'h0, data}, 32'h0);
      check("rst_valid", {31'h0, valid}, 32'h0);
      check("rst_ferr",  {31'h0, frame_err}, 32'h0);
      check("rst_busy",  {31'h0, busy}, 32'h0);
      reset = 1'b1;
      idle_clks(5);

      // 1: two bytes back-to-back
      send_byte(8'h34, 1'b1);
      send_byte(8'hA5, 1'b1);
      idle_clks(5);
      exp_valid++;
      check("t1_valid_cnt", valid_cnt, exp_valid);
      check("t1_data",      {16'h0, data}, 32'hA534);
      check("t1_ferr_cnt",  fe_cnt, exp_fe);
      check("t1_busy",      {31'h0, busy}, 32'h0);

      // 2: partial word is not exposed
      send_byte(8'h34, 1'b1);
      idle_clks(40);
      check("t2_partial_valid", valid_cnt, exp_valid);
      check("t2_partial_data",  {16'h0, data}, 32'hA534);
      check("t2_partial_busy",  {31'h0, busy}, 32'h0);
      send_byte(8'h12, 1'b1);
      idle_clks(5);
      exp_valid++;
      check("t2_valid_cnt", valid_cnt, exp_valid);
      check("t2_data",      {16'h0, data}, 32'h1234);

      // 3: framing error, then recovery
      send_byte(8'h55, 1'b0);
      idle_clks(6);
      exp_fe++;
      check("t3_ferr_cnt",  fe_cnt, exp_fe);
      check("t3_busy",      {31'h0, busy}, 32'h0);
      check("t3_data_hold", {16'h0, data}, 32'h1234);
      check("t3_no_valid",  valid_cnt, exp_valid);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      idle_clks(5);
      exp_valid++;
      check("t3_data",      {16'h0, data}, 32'h0201);
      check("t3_valid_cnt", valid_cnt, exp_valid);

      // 4: short glitch on idle line is rejected
      RxD = 1'b0;
      idle_clks(5);
      check("t4_busy_start", {31'h0, busy}, 32'h1);
      RxD = 1'b1;
      idle_clks(20);
      check("t4_busy_idle",  {31'h0, busy}, 32'h0);
      check("t4_ferr_cnt",   fe_cnt, exp_fe);
      check("t4_valid_cnt",  valid_cnt, exp_valid);
      send_byte(8'hEF, 1'b1);
      send_byte(8'hBE, 1'b1);
      idle_clks(5);
      exp_valid++;
      check("t4_data",      {16'h0, data}, 32'hBEEF);
      check("t4_valid_cnt2", valid_cnt, exp_valid);

      // 5: reset during bit 4 of the second byte
      send_byte(8'h77, 1'b1);
      RxD = 1'b0;
      idle_clks(CPB);
      for (int i = 0; i < 4; i++) begin
         RxD = i[0];
         idle_clks(CPB);
      end
      RxD = 1'b1;
      idle_clks(CPB / 2);
      check("t5_busy_pre", {31'h0, busy}, 32'h1);
      reset = 1'b0;
      idle_clks(3);
      check("t5_busy",  {31'h0, busy}, 32'h0);
      check("t5_data",  {16'h0, data}, 32'h0);
      check("t5_valid", {31'h0, valid}, 32'h0);
      reset = 1'b1;
      idle_clks(20);
      check("t5_busy_after", {31'h0, busy}, 32'h0);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h00, 1'b1);
      idle_clks(5);
      exp_valid++;
      check("t5_data_after", {16'h0, data}, 32'h00FF);
      check("t5_valid_cnt",  valid_cnt, exp_valid);

`ifdef MULTIBYTE_RX_TIMEOUT_EN
      // 6: inter-byte timeout drops the partial word
      send_byte(8'h11, 1'b1);
      idle_clks(21 * CPB);
      exp_fe++;
      check("t6_ferr_cnt",  fe_cnt, exp_fe);
      check("t6_no_valid",  valid_cnt, exp_valid);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      idle_clks(5);
      exp_valid++;
      check("t6_data",      {16'h0, data}, 32'h3322);
      check("t6_valid_cnt", valid_cnt, exp_valid);
`endif

      check("ferr_total",         fe_cnt, exp_fe);
      check("valid_ferr_overlap", both_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
